// File: rtl/alu_req_arbiter.sv
// rtl/alu_req_arbiter.sv - two-requester round-robin front end for a shared combinational ALU
module alu_req_arbiter #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [7:0]           req_opcode,
  input  logic [2*WIDTH-1:0]   req_operand1,
  input  logic [2*WIDTH-1:0]   req_operand2,
  output logic [3:0]           alu_opcode,
  output logic [WIDTH-1:0]     alu_operand1,
  output logic [WIDTH-1:0]     alu_operand2,
  input  logic [WIDTH-1:0]     alu_result,
  input  logic                 alu_carry_out,
  input  logic [2*WIDTH-1:0]   alu_product,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic                 resp_id,
  output logic [2*WIDTH-1:0]   resp_data,
  output logic                 resp_carry,
  output logic                 busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_C3  = 4'd3;
  localparam logic [3:0] OP_C4  = 4'd4;

  // EXEC counter loads this for MUL so the final EXEC cycle is reached after MUL_CYCLES cycles
  localparam logic [3:0] MUL_LAST = 4'(MUL_CYCLES - 1);

  logic [1:0]       state;
  logic             ptr;
  logic [3:0]       exec_cnt;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             id_q;

  logic             any_req;
  logic             winner;
  logic             grant;
  logic [3:0]       sel_op;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic             op_has_carry;

  // Round-robin pick: pointer breaks ties, a lone requester always wins
  always_comb begin
    any_req   = |req_valid;
    winner    = (req_valid == 2'b11) ? ptr : req_valid[1];
    grant     = (state == ST_IDLE) && any_req;
    req_ready = 2'b00;
    if (grant) begin
      req_ready = winner ? 2'b10 : 2'b01;
    end
    sel_op = winner ? req_opcode[7:4] : req_opcode[3:0];
    sel_a  = winner ? req_operand1[2*WIDTH-1:WIDTH] : req_operand1[WIDTH-1:0];
    sel_b  = winner ? req_operand2[2*WIDTH-1:WIDTH] : req_operand2[WIDTH-1:0];
  end

  // Carry is meaningful only for the arithmetic/shift codes 0,1,3,4
  always_comb begin
    op_has_carry = (op_q == OP_ADD) || (op_q == OP_SUB) ||
                   (op_q == OP_C3)  || (op_q == OP_C4);
  end

  // Controller: grant in IDLE, time EXEC, hold response until consumed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      ptr        <= 1'b0;
      exec_cnt   <= 4'd0;
      op_q       <= 4'd0;
      a_q        <= '0;
      b_q        <= '0;
      id_q       <= 1'b0;
      resp_data  <= '0;
      resp_carry <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant) begin
            state    <= ST_EXEC;
            ptr      <= ~winner;
            op_q     <= sel_op;
            a_q      <= sel_a;
            b_q      <= sel_b;
            id_q     <= winner;
            exec_cnt <= (sel_op == OP_MUL) ? MUL_LAST : 4'd0;
          end
        end
        ST_EXEC: begin
          if (exec_cnt == 4'd0) begin
            state      <= ST_RESP;
            resp_data  <= (op_q == OP_MUL) ? alu_product
                                           : {{WIDTH{1'b0}}, alu_result};
            resp_carry <= op_has_carry ? alu_carry_out : 1'b0;
          end else begin
            exec_cnt <= exec_cnt - 4'd1;
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // ALU inputs come only from the captured registers so they stay still through EXEC
  always_comb begin
    alu_opcode   = op_q;
    alu_operand1 = a_q;
    alu_operand2 = b_q;
    resp_valid   = (state == ST_RESP);
    resp_id      = id_q;
    busy         = (state != ST_IDLE);
  end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// tb/tb_alu_req_arbiter.sv - directed self-checking bench for alu_req_arbiter
module tb_alu_req_arbiter;

  localparam int W = 32;

  logic           clk;
  logic           rst_n;
  logic [1:0]     req_valid;
  logic [1:0]     req_ready;
  logic [7:0]     req_opcode;
  logic [2*W-1:0] req_operand1;
  logic [2*W-1:0] req_operand2;
  logic [3:0]     alu_opcode;
  logic [W-1:0]   alu_operand1;
  logic [W-1:0]   alu_operand2;
  logic [W-1:0]   alu_result;
  logic           alu_carry_out;
  logic [2*W-1:0] alu_product;
  logic           resp_valid;
  logic           resp_ready;
  logic           resp_id;
  logic [2*W-1:0] resp_data;
  logic           resp_carry;
  logic           busy;

  int n_cmp;
  int n_bad;

  alu_req_arbiter #(.WIDTH(W), .MUL_CYCLES(3)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_opcode   (req_opcode),
    .req_operand1 (req_operand1),
    .req_operand2 (req_operand2),
    .alu_opcode   (alu_opcode),
    .alu_operand1 (alu_operand1),
    .alu_operand2 (alu_operand2),
    .alu_result   (alu_result),
    .alu_carry_out(alu_carry_out),
    .alu_product  (alu_product),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_id      (resp_id),
    .resp_data    (resp_data),
    .resp_carry   (resp_carry),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in shared ALU: 0 ADD, 1 SUB (carry = borrow), 2 MUL, 5 AND, 6 OR
  always_comb begin
    alu_result    = '0;
    alu_carry_out = 1'b0;
    alu_product   = alu_operand1 * alu_operand2;
    case (alu_opcode)
      4'd0: {alu_carry_out, alu_result} = {1'b0, alu_operand1} + {1'b0, alu_operand2};
      4'd1: begin
        alu_result    = alu_operand1 - alu_operand2;
        alu_carry_out = (alu_operand1 < alu_operand2);
      end
      4'd5: alu_result = alu_operand1 & alu_operand2;
      4'd6: alu_result = alu_operand1 | alu_operand2;
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Looks for a grant in the current cycle first, then in later cycles
  task automatic wait_grant(input string tag, output logic [1:0] g);
    g = 2'b00;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (req_ready != 2'b00) begin
        g = req_ready;
        break;
      end
      @(negedge clk);
    end
    if (g == 2'b00) check({tag, "_grant_timeout"}, 64'd0, 64'd1);
  endtask

  // Steps cycle by cycle from the grant until resp_valid; returns cycles elapsed
  task automatic wait_resp(input string tag, output int lat);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (resp_valid) begin
        lat = i;
        break;
      end
    end
    if (lat == 0) check({tag, "_resp_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  logic [1:0] g;
  int         lat;
  int         seen;
  logic [1:0] exp_g;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    req_valid = 2'b00;
    req_opcode = 8'h00;
    req_operand1 = '0;
    req_operand2 = '0;
    resp_ready = 1'b1;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_ready",  {62'd0, req_ready}, 64'd0);
    check("rst_rvalid", {63'd0, resp_valid}, 64'd0);
    check("rst_busy",   {63'd0, busy}, 64'd0);
    check("rst_data",   resp_data, 64'd0);
    check("rst_aluop",  {60'd0, alu_opcode}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single ADD on rq0: 0xFFFFFFFF + 1
    req_opcode   = 8'h00;
    req_operand1 = {32'h0, 32'hFFFF_FFFF};
    req_operand2 = {32'h0, 32'h0000_0001};
    req_valid    = 2'b01;
    wait_grant("add", g);
    check("add_grant", {62'd0, g}, 64'd1);
    @(negedge clk);
    req_valid = 2'b00;
    check("add_exec_busy", {63'd0, busy}, 64'd1);
    check("add_exec_rv",   {63'd0, resp_valid}, 64'd0);
    @(negedge clk);
    check("add_rv",    {63'd0, resp_valid}, 64'd1);
    check("add_data",  resp_data, 64'd0);
    check("add_carry", {63'd0, resp_carry}, 64'd1);
    check("add_id",    {63'd0, resp_id}, 64'd0);
    @(negedge clk);
    check("add_idle_busy", {63'd0, busy}, 64'd0);

    // Contention after a fresh reset: rq0 AND, rq1 OR, grants 0,1,0,1
    do_reset();
    req_opcode   = 8'h65;
    req_operand1 = {32'h1200_0000, 32'hF0F0_1234};
    req_operand2 = {32'h0000_0034, 32'h0FF0_FFFF};
    req_valid    = 2'b11;
    for (int t = 0; t < 4; t++) begin
      exp_g = (t % 2 == 0) ? 2'b01 : 2'b10;
      wait_grant("rr", g);
      check($sformatf("rr%0d_grant", t), {62'd0, g}, {62'd0, exp_g});
      wait_resp("rr", lat);
      check($sformatf("rr%0d_lat", t), 64'(lat), 64'd2);
      check($sformatf("rr%0d_id", t), {63'd0, resp_id}, {63'd0, exp_g[1]});
      check($sformatf("rr%0d_data", t), resp_data,
            exp_g[1] ? 64'h0000_0000_1200_0034 : 64'h0000_0000_00F0_1234);
      check($sformatf("rr%0d_resp_noready", t), {62'd0, req_ready}, 64'd0);
    end
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);

    // MUL on rq1: 0x10000 * 0x10000, latency MUL_CYCLES+1
    req_opcode   = 8'h20;
    req_operand1 = {32'h0001_0000, 32'h0};
    req_operand2 = {32'h0001_0000, 32'h0};
    req_valid    = 2'b10;
    wait_grant("mul", g);
    check("mul_grant", {62'd0, g}, 64'd2);
    @(negedge clk);
    req_valid = 2'b00;
    lat = 1;
    while (!resp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("mul_lat",   64'(lat), 64'd4);
    check("mul_data",  resp_data, 64'h0000_0001_0000_0000);
    check("mul_carry", {63'd0, resp_carry}, 64'd0);
    check("mul_id",    {63'd0, resp_id}, 64'd1);
    @(negedge clk);

    // Backpressure: rq0 SUB 3-5 held for 5 cycles while rq1 waits
    resp_ready   = 1'b0;
    req_opcode   = 8'h01;
    req_operand1 = {32'h7, 32'h3};
    req_operand2 = {32'h1, 32'h5};
    req_valid    = 2'b01;
    wait_grant("sub", g);
    check("sub_grant", {62'd0, g}, 64'd1);
    @(negedge clk);
    req_opcode = 8'h11;
    req_valid  = 2'b10;
    wait_resp("sub", lat);
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bp%0d_rv", c),    {63'd0, resp_valid}, 64'd1);
      check($sformatf("bp%0d_data", c),  resp_data, 64'h0000_0000_FFFF_FFFE);
      check($sformatf("bp%0d_carry", c), {63'd0, resp_carry}, 64'd1);
      check($sformatf("bp%0d_ready", c), {62'd0, req_ready}, 64'd0);
      @(negedge clk);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    wait_grant("bp_next", g);
    check("bp_next_grant", {62'd0, g}, 64'd2);
    wait_resp("bp_next", lat);
    check("bp_next_data", resp_data, 64'h0000_0000_0000_0006);
    check("bp_next_id",   {63'd0, resp_id}, 64'd1);
    req_valid = 2'b00;
    @(negedge clk);

    // Reset during a MUL's EXEC phase aborts it
    req_opcode   = 8'h02;
    req_operand1 = {32'h0, 32'h1234};
    req_operand2 = {32'h0, 32'h10};
    req_valid    = 2'b01;
    wait_grant("abort", g);
    @(negedge clk);
    req_valid = 2'b00;
    check("abort_busy_pre", {63'd0, busy}, 64'd1);
    rst_n = 1'b0;
    #1;
    check("abort_busy",  {63'd0, busy}, 64'd0);
    check("abort_rv",    {63'd0, resp_valid}, 64'd0);
    check("abort_aluop", {60'd0, alu_opcode}, 64'd0);
    check("abort_opnd",  {alu_operand1, alu_operand2}, 64'd0);
    check("abort_data",  resp_data, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (resp_valid) seen++;
    end
    check("abort_no_resp", 64'(seen), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
